// File: rtl/scaled_frame_reader.sv
// Streams the downscaled RGB888 frame buffer out as 8-bit luma in raster order,
// with SOF/EOF and (x,y) tags over a valid/ready handshake.
module scaled_frame_reader #(
    parameter int IMG_W  = 20,
    parameter int IMG_H  = 20,
    parameter int ADDR_W = 9
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     FRAME_DONE,
    output logic                     read,
    output logic [ADDR_W-1:0]        RD_ADDR,
    input  logic [7:0]               VGA_R_in,
    input  logic [7:0]               VGA_G_in,
    input  logic [7:0]               VGA_B_in,
    output logic [7:0]               PIX_GRAY,
    output logic [$clog2(IMG_W)-1:0] PIX_X,
    output logic [$clog2(IMG_H)-1:0] PIX_Y,
    output logic                     PIX_SOF,
    output logic                     PIX_EOF,
    output logic                     PIX_VALID,
    input  logic                     PIX_READY,
    output logic                     BUSY,
    output logic                     OVERRUN
);

    localparam int X_W = $clog2(IMG_W);
    localparam int Y_W = $clog2(IMG_H);
    localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

    state_t         state, state_next;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           pending;
    logic           xfer;
    logic           last_pix;
    logic           restart;
    logic [15:0]    luma_sum;

    assign xfer     = (state == SEND) && PIX_VALID && PIX_READY;
    assign last_pix = (x == X_LAST) && (y == Y_LAST);
    // A request arriving on the very last handshake restarts immediately, same as a queued one.
    assign restart  = pending || FRAME_DONE;

    // Weights sum to 256, so the top byte of the 16-bit sum is the luma.
    assign luma_sum = 16'd77 * {8'd0, VGA_R_in}
                    + 16'd150 * {8'd0, VGA_G_in}
                    + 16'd29 * {8'd0, VGA_B_in};

    always_comb begin
        state_next = state;
        read       = 1'b0;
        case (state)
            IDLE: begin
                if (FRAME_DONE || pending)
                    state_next = FETCH;
            end
            FETCH: begin
                read       = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                if (xfer) begin
                    if (!last_pix || restart)
                        state_next = FETCH;
                    else
                        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            RD_ADDR   <= '0;
            x         <= '0;
            y         <= '0;
            pending   <= 1'b0;
            BUSY      <= 1'b0;
            OVERRUN   <= 1'b0;
            PIX_GRAY  <= '0;
            PIX_X     <= '0;
            PIX_Y     <= '0;
            PIX_SOF   <= 1'b0;
            PIX_EOF   <= 1'b0;
            PIX_VALID <= 1'b0;
        end else begin
            state <= state_next;

            // Requests arriving during a readout queue one frame deep; any beyond that are lost.
            if (FRAME_DONE && state != IDLE && !(xfer && last_pix)) begin
                if (pending)
                    OVERRUN <= 1'b1;
                else
                    pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (FRAME_DONE || pending) begin
                        RD_ADDR <= '0;
                        x       <= '0;
                        y       <= '0;
                        BUSY    <= 1'b1;
                        pending <= 1'b0;
                    end
                end
                FETCH: begin
                    PIX_GRAY  <= 8'(luma_sum >> 8);
                    PIX_X     <= x;
                    PIX_Y     <= y;
                    PIX_SOF   <= (x == '0) && (y == '0);
                    PIX_EOF   <= last_pix;
                    PIX_VALID <= 1'b1;
                end
                SEND: begin
                    if (xfer) begin
                        PIX_VALID <= 1'b0;
                        if (!last_pix) begin
                            RD_ADDR <= RD_ADDR + 1'b1;
                            if (x == X_LAST) begin
                                x <= '0;
                                y <= y + 1'b1;
                            end else begin
                                x <= x + 1'b1;
                            end
                        end else if (restart) begin
                            RD_ADDR <= '0;
                            x       <= '0;
                            y       <= '0;
                            pending <= pending && FRAME_DONE;
                        end else begin
                            BUSY <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_scaled_frame_reader.sv
// Scoreboard bench for scaled_frame_reader: expected pixels are queued at stimulus
// time and a negedge monitor pops them on every accepted handshake.
module tb_scaled_frame_reader;

    localparam int IMG_W  = 20;
    localparam int IMG_H  = 20;
    localparam int ADDR_W = 9;
    localparam int NPIX   = IMG_W * IMG_H;

    typedef struct packed {
        logic [7:0] gray;
        logic [4:0] x;
        logic [4:0] y;
        logic       sof;
        logic       eof;
    } pix_t;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              FRAME_DONE;
    logic              read;
    logic [ADDR_W-1:0] RD_ADDR;
    logic [7:0]        VGA_R_in, VGA_G_in, VGA_B_in;
    logic [7:0]        PIX_GRAY;
    logic [4:0]        PIX_X;
    logic [4:0]        PIX_Y;
    logic              PIX_SOF, PIX_EOF, PIX_VALID, PIX_READY, BUSY, OVERRUN;

    logic [23:0] buffer [0:511];
    pix_t        exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 CLK = ~CLK;

    assign {VGA_R_in, VGA_G_in, VGA_B_in} = buffer[RD_ADDR];

    scaled_frame_reader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .RESET(RESET), .FRAME_DONE(FRAME_DONE), .read(read), .RD_ADDR(RD_ADDR),
        .VGA_R_in(VGA_R_in), .VGA_G_in(VGA_G_in), .VGA_B_in(VGA_B_in),
        .PIX_GRAY(PIX_GRAY), .PIX_X(PIX_X), .PIX_Y(PIX_Y), .PIX_SOF(PIX_SOF),
        .PIX_EOF(PIX_EOF), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
        .BUSY(BUSY), .OVERRUN(OVERRUN)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Mode 0: every channel equals the low address byte. Mode 1: four luma probe colours then black.
    task automatic load_buffer(input int mode);
        for (int a = 0; a < 512; a++) begin
            if (mode == 0) buffer[a] = {3{8'(a)}};
            else           buffer[a] = 24'h000000;
        end
        if (mode == 1) begin
            buffer[0] = 24'hFF0000;
            buffer[1] = 24'h00FF00;
            buffer[2] = 24'h0000FF;
            buffer[3] = 24'hFFFFFF;
        end
    endtask

    // Probe lumas: 19635>>8=76, 38250>>8=149, 7395>>8=28, 65280>>8=255.
    task automatic push_frame(input int mode);
        logic [7:0] probe [0:3];
        pix_t p;
        probe = '{8'd76, 8'd149, 8'd28, 8'd255};
        for (int a = 0; a < NPIX; a++) begin
            if (mode == 0)  p.gray = 8'(a);
            else if (a < 4) p.gray = probe[a];
            else            p.gray = 8'd0;
            p.x   = 5'(a % IMG_W);
            p.y   = 5'(a / IMG_W);
            p.sof = (a == 0);
            p.eof = (a == NPIX - 1);
            exp_q.push_back(p);
        end
    endtask

    task automatic apply_stimulus;
        FRAME_DONE = 1'b1;
        @(posedge CLK); #1;
        FRAME_DONE = 1'b0;
    endtask

    task automatic wait_pixel(input int px, input int py);
        logic found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(posedge CLK); #1;
            if (PIX_VALID && PIX_X == 5'(px) && PIX_Y == 5'(py)) found = 1'b1;
        end
        check_output($sformatf("reach_pixel_%0d_%0d", px, py), {31'd0, found}, 32'd1);
    endtask

    task automatic wait_idle(input int max_cycles, output int cycles);
        cycles = 0;
        while (BUSY && cycles < max_cycles) begin
            @(posedge CLK); #1;
            cycles++;
        end
        check_output("busy_drops_in_time", {31'd0, BUSY}, 32'd0);
    endtask

    always @(negedge CLK) begin
        if (!RESET && PIX_VALID && PIX_READY) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_pixel: got x=%0d y=%0d, required no pixel", PIX_X, PIX_Y);
            end else begin
                pix_t e;
                e = exp_q.pop_front();
                check_output("pixel", {12'd0, PIX_GRAY, PIX_X, PIX_Y, PIX_SOF, PIX_EOF}, {12'd0, e});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cyc;
        RESET = 1'b1;
        FRAME_DONE = 1'b0;
        PIX_READY = 1'b1;
        load_buffer(0);

        $display("[TB] reset");
        repeat (2) begin
            @(negedge CLK);
            check_output("reset_no_read", {31'd0, read}, 32'd0);
        end
        @(posedge CLK); #1;
        RESET = 1'b0;
        check_output("reset_outputs",
                     {read, RD_ADDR, PIX_GRAY, PIX_X, PIX_Y, PIX_SOF, PIX_EOF, PIX_VALID, BUSY, OVERRUN},
                     32'd0);

        $display("[TB] full frame, ramp pattern");
        push_frame(0);
        FRAME_DONE = 1'b1;
        @(posedge CLK); #1;
        FRAME_DONE = 1'b0;
        check_output("first_fetch", {29'd0, BUSY, read, PIX_VALID}, {29'd0, 3'b110});
        @(posedge CLK); #1;
        check_output("first_valid", {31'd0, PIX_VALID}, 32'd1);
        wait_idle(2000, cyc);
        check_output("frame_cycles", 32'(cyc + 1), 32'd800);
        check_output("frame1_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] luma probes");
        load_buffer(1);
        push_frame(1);
        apply_stimulus();
        wait_idle(2000, cyc);
        check_output("luma_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] backpressure on pixel 5");
        load_buffer(0);
        push_frame(0);
        apply_stimulus();
        wait_pixel(5, 0);
        PIX_READY = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            check_output("stall_hold", {13'd0, PIX_VALID, read, PIX_GRAY, PIX_X, RD_ADDR},
                         {13'd0, 1'b1, 1'b0, 8'd5, 5'd5, 9'd5});
        end
        PIX_READY = 1'b1;
        @(posedge CLK); #1;
        check_output("release_fetch", {21'd0, PIX_VALID, read, RD_ADDR}, {21'd0, 1'b0, 1'b1, 9'd6});
        @(posedge CLK); #1;
        check_output("pixel6_valid", {18'd0, PIX_VALID, PIX_GRAY, PIX_X}, {18'd0, 1'b1, 8'd6, 5'd6});
        wait_idle(2000, cyc);
        check_output("stall_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] pending restart");
        push_frame(0);
        push_frame(0);
        apply_stimulus();
        wait_pixel(0, 5);
        apply_stimulus();
        wait_pixel(19, 19);
        @(posedge CLK); #1;
        check_output("restart_fetch", {20'd0, read, RD_ADDR, BUSY, OVERRUN},
                     {20'd0, 1'b1, 9'd0, 1'b1, 1'b0});
        wait_idle(2000, cyc);
        check_output("pending_no_overrun", {31'd0, OVERRUN}, 32'd0);
        check_output("pending_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] overrun");
        push_frame(0);
        push_frame(0);
        apply_stimulus();
        wait_pixel(10, 2);
        apply_stimulus();
        wait_pixel(10, 7);
        apply_stimulus();
        wait_idle(4000, cyc);
        check_output("overrun_set", {31'd0, OVERRUN}, 32'd1);
        check_output("overrun_drained", 32'(exp_q.size()), 32'd0);
        repeat (20) @(posedge CLK);
        #1;
        check_output("overrun_idle", {30'd0, BUSY, PIX_VALID}, 32'd0);

        $display("[TB] reset mid-frame");
        push_frame(0);
        apply_stimulus();
        wait_pixel(0, 10);
        RESET = 1'b1;
        @(posedge CLK); #1;
        check_output("midframe_reset", {19'd0, PIX_VALID, BUSY, read, OVERRUN, RD_ADDR}, 32'd0);
        RESET = 1'b0;
        exp_q.delete();
        push_frame(0);
        apply_stimulus();
        wait_idle(2000, cyc);
        check_output("after_reset_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
